sonic_scheduler: RTL and testbench
==================================

SONIC_SCHEDULER -- requirements
Module: sonic_scheduler

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 100, meaning clk cycles per 1 us tick.
REQ-002 SHALL have parameter TRIG_US, default 10, meaning trigger pulse width in us.
REQ-003 SHALL have parameter TIMEOUT_US, default 30000, meaning maximum wait for echo rise plus echo high time, in us.
REQ-004 SHALL have parameter SLOT_US, default 50000, meaning length of one sensor slot in us.
REQ-005 SHALL have parameter NEAR_CM, default 10, meaning near-threshold distance in cm.
REQ-006 SHALL have port clk, input, 1 bit: the single 100 MHz clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port enable, input, 1 bit: run the scheduler when high.
REQ-009 SHALL have ports echo0 and echo1, input, 1 bit each: asynchronous sensor echo pins.
REQ-010 SHALL have ports trig0 and trig1, output, 1 bit each: sensor trigger pins.
REQ-011 SHALL have ports distance0 and distance1, output, 20 bits each: last result in cm.
REQ-012 SHALL have ports valid0 and valid1, output, 1 bit each: one-cycle pulse on result update.
REQ-013 SHALL have ports timeout0 and timeout1, output, 1 bit each: last measurement timed out.
REQ-014 SHALL have ports near0 and near1, output, 1 bit each: distanceN <= NEAR_CM and timeoutN low.
REQ-015 SHALL have port active, output, 1 bit: index of the sensor owning the current slot.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 Each echo pin SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signal only.
REQ-018 A us-tick prescaler SHALL pulse once every CLK_PER_US cycles, restarting at the beginning of each slot.
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, HOLD.
REQ-020 IDLE -> TRIG SHALL occur on the first clk with enable=1, and SHALL start a slot for sensor `active`.
REQ-021 In TRIG, trig[active] SHALL be high for exactly TRIG_US*CLK_PER_US cycles (1000 by default); the other trigger SHALL stay low; the state then SHALL go to WAIT_RISE.
REQ-022 In WAIT_RISE, a synchronized rising edge SHALL go to MEASURE; a level already high on entry SHALL NOT count.
REQ-023 In MEASURE, the echo width SHALL be counted in us ticks (20-bit, saturating); a synchronized falling edge SHALL go to HOLD.
REQ-024 On that falling edge, distance[active] SHALL be set to width_us*17/1000 (integer, truncating), and valid[active] SHALL pulse in the same cycle; the total is 3 clk after the echo pin falls.
REQ-025 If TIMEOUT_US elapses from TRIG end while in WAIT_RISE or MEASURE, the result SHALL be distance[active]=999 with timeout[active]=1 and valid[active] pulsed, then the state SHALL go to HOLD.
REQ-026 A successful measurement SHALL clear timeout[active].
REQ-027 HOLD SHALL wait until SLOT_US us after slot start.
REQ-028 At the end of HOLD, active SHALL toggle; the FSM SHALL then go to TRIG if enable=1, else to IDLE.
REQ-029 Deasserting enable mid-slot SHALL NOT abort the slot; the slot SHALL complete, and then the FSM SHALL go to IDLE.
REQ-030 Echo activity on the non-active sensor SHALL be ignored.
REQ-031 near0 and near1 SHALL be registered and SHALL update in the cycle after the matching distance update.
REQ-032 valid0 and valid1 SHALL never be high in the same cycle.

Reset
REQ-033 While rst=0, the block SHALL force: state IDLE, active=0, trig0/1=0, distance0/1=0, valid0/1=0, timeout0/1=0, near0/1=0, busy=0, and clear all counters and synchronizers.
REQ-034 Asserting reset mid-slot SHALL abort immediately.
REQ-035 After reset release, the first slot SHALL use sensor 0.

Verification
REQ-036 Reset release with enable=1: trig0 SHALL go high for exactly 1000 cycles, trig1 SHALL stay 0, and trig1 SHALL rise 5,000,000 cycles after trig0 rose.
REQ-037 echo0 high for 1176 us in slot 0: distance0=19 and valid0 SHALL pulse once, 3 clk after echo0 falls; near0=0.
REQ-038 echo1 high for 588 us: distance1=9 and near1=1 one cycle after valid1.
REQ-039 echo0 never rises: at 30,000 us after trig0 falls, distance0=999, timeout0=1 and valid0 pulses; the next good echo of 1176 us gives distance0=19 and timeout0=0.
REQ-040 enable dropped 100 us into slot 0: slot 0 SHALL complete, then busy=0 and trig1 SHALL never assert; re-enable SHALL start at sensor 1.
REQ-041 rst asserted during MEASURE: all outputs SHALL be 0 asynchronously, and after release the sequence SHALL restart with trig0.

Source files
------------

// File: rtl/sonic_scheduler.sv
// Round-robin scheduler for two ultrasonic ranging sensors: trigger, echo timing,
// distance conversion and timeout handling, one fixed-length slot per sensor.
module sonic_scheduler #(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned SLOT_US    = 50000,
  parameter int unsigned NEAR_CM    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo0,
  input  logic        echo1,
  output logic        trig0,
  output logic        trig1,
  output logic [19:0] distance0,
  output logic [19:0] distance1,
  output logic        valid0,
  output logic        valid1,
  output logic        timeout0,
  output logic        timeout1,
  output logic        near0,
  output logic        near1,
  output logic        active,
  output logic        busy
);

  localparam int unsigned DIST_W = 20;
  localparam int unsigned PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned US_MAX = (SLOT_US > TRIG_US + TIMEOUT_US) ? SLOT_US
                                                                    : TRIG_US + TIMEOUT_US;
  localparam int unsigned US_W   = $clog2(US_MAX + 1);

  localparam logic [PRE_W-1:0]  PRE_END   = PRE_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]   TRIG_END  = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]   TO_END    = US_W'(TRIG_US + TIMEOUT_US - 1);
  localparam logic [US_W-1:0]   SLOT_END  = US_W'(SLOT_US - 1);
  localparam logic [DIST_W-1:0] TO_DIST   = DIST_W'(999);
  localparam logic [DIST_W-1:0] NEAR_LIM  = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] WIDTH_MAX = {DIST_W{1'b1}};

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLD} state_e;

  state_e                  state_q, state_d;
  logic                    active_q, active_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [US_W-1:0]         us_q, us_d;
  logic [DIST_W-1:0]       width_q, width_d;
  logic [1:0][DIST_W-1:0]  dist_q, dist_d;
  logic [1:0]              valid_q, valid_d;
  logic [1:0]              tout_q, tout_d;
  logic [1:0]              near_q, near_d;
  logic [1:0]              trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic [1:0]              meta_q, sync_q, prev_q;

  logic                    tick;
  logic                    timed_out;
  logic                    echo_rise;
  logic                    echo_fall;
  logic [31:0]             prod;
  logic [DIST_W-1:0]       width_cm;

  // Slot-relative microsecond tick; only the active sensor's synchronized edges matter
  assign tick      = (pre_q == PRE_END);
  assign timed_out = tick && (us_q == TO_END);
  assign echo_rise = sync_q[active_q] & ~prev_q[active_q];
  assign echo_fall = ~sync_q[active_q] & prev_q[active_q];
  assign prod      = 32'(width_q) * 32'd17;
  assign width_cm  = DIST_W'(prod / 32'd1000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {echo1, echo0};
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      pre_q    <= '0;
      us_q     <= '0;
      width_q  <= '0;
      dist_q   <= '0;
      valid_q  <= '0;
      tout_q   <= '0;
      near_q   <= '0;
      trig_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pre_q    <= pre_d;
      us_q     <= us_d;
      width_q  <= width_d;
      dist_q   <= dist_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      near_q   <= near_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    us_d     = tick ? us_q + US_W'(1) : us_q;
    width_d  = width_q;
    dist_d   = dist_q;
    valid_d  = '0;
    tout_d   = tout_q;
    near_d   = near_q;

    case (state_q)
      IDLE: begin
        pre_d = '0;
        us_d  = '0;
        if (enable) state_d = TRIG;
      end
      TRIG: begin
        if (tick && (us_q == TRIG_END)) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (timed_out) begin
          dist_d[active_q]  = TO_DIST;
          tout_d[active_q]  = 1'b1;
          valid_d[active_q] = 1'b1;
          state_d           = HOLD;
        end else if (echo_rise) begin
          width_d = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (tick && (width_q != WIDTH_MAX)) width_d = width_q + DIST_W'(1);
        if (echo_fall) begin
          dist_d[active_q]  = width_cm;
          tout_d[active_q]  = 1'b0;
          valid_d[active_q] = 1'b1;
          state_d           = HOLD;
        end else if (timed_out) begin
          dist_d[active_q]  = TO_DIST;
          tout_d[active_q]  = 1'b1;
          valid_d[active_q] = 1'b1;
          state_d           = HOLD;
        end
      end
      HOLD: begin
        // Slot boundary: hand over to the other sensor and restart slot timing
        if (tick && (us_q == SLOT_END)) begin
          active_d = ~active_q;
          pre_d    = '0;
          us_d     = '0;
          state_d  = enable ? TRIG : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Near flags follow one cycle behind each distance update
    for (int i = 0; i < 2; i++) begin
      if (valid_q[i]) near_d[i] = (dist_q[i] <= NEAR_LIM) && !tout_q[i];
    end

    trig_d = '0;
    if (state_d == TRIG) trig_d[active_d] = 1'b1;
    busy_d = (state_d != IDLE);
  end

  assign trig0     = trig_q[0];
  assign trig1     = trig_q[1];
  assign distance0 = dist_q[0];
  assign distance1 = dist_q[1];
  assign valid0    = valid_q[0];
  assign valid1    = valid_q[1];
  assign timeout0  = tout_q[0];
  assign timeout1  = tout_q[1];
  assign near0     = near_q[0];
  assign near1     = near_q[1];
  assign active    = active_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sonic_scheduler.sv
// Directed bench for sonic_scheduler with shortened timing: 2 clk/us, 10 us trigger,
// 1500 us timeout, 2000 us slots.
module tb_sonic_scheduler;

  localparam int unsigned TRIG_CYC = 20;
  localparam int unsigned SLOT_CYC = 4000;
  localparam int unsigned TO_CYC   = 3000;
  localparam int unsigned W1176    = 2352;

  logic        clk, rst, enable, echo0, echo1;
  logic        trig0, trig1, valid0, valid1, timeout0, timeout1, near0, near1, active, busy;
  logic [19:0] distance0, distance1;

  int tests, failed;
  int cyc, v0_cnt, v1_cnt, both_cnt, tr1_cnt;

  sonic_scheduler #(
    .CLK_PER_US(2), .TRIG_US(10), .TIMEOUT_US(1500), .SLOT_US(2000), .NEAR_CM(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo0(echo0), .echo1(echo1),
    .trig0(trig0), .trig1(trig1), .distance0(distance0), .distance1(distance1),
    .valid0(valid0), .valid1(valid1), .timeout0(timeout0), .timeout1(timeout1),
    .near0(near0), .near1(near1), .active(active), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid0 === 1'b1) v0_cnt++;
    if (valid1 === 1'b1) v1_cnt++;
    if (valid0 === 1'b1 && valid1 === 1'b1) both_cnt++;
    if (trig1 === 1'b1) tr1_cnt++;
  end

  function automatic logic [63:0] outs();
    return 64'({trig0, trig1, distance0, distance1, valid0, valid1,
                timeout0, timeout1, near0, near1, active, busy});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n, t0, t4, fall_cyc, tr1_snap;
    tests = 0; failed = 0; cyc = 0;
    v0_cnt = 0; v1_cnt = 0; both_cnt = 0; tr1_cnt = 0;
    rst = 1'b0; enable = 1'b0; echo0 = 1'b0; echo1 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    check("reset_outputs_enabled", outs(), 64'd0);

    // Slot 0: sensor 0, echo of 1176 us
    rst = 1'b1;
    n = 0;
    while (trig0 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("trig0_first_rise", 64'(trig0), 64'd1);
    check("first_active", 64'(active), 64'd0);
    check("busy_in_slot", 64'(busy), 64'd1);
    t0 = cyc;
    n = 0;
    while (trig0 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("trig0_width", 64'(n), 64'(TRIG_CYC));
    check("trig1_quiet_slot0", 64'(tr1_cnt), 64'd0);

    echo0 = 1'b1;
    repeat (W1176) @(negedge clk);
    echo0 = 1'b0;
    @(negedge clk); check("valid0_lat1", 64'(valid0), 64'd0);
    @(negedge clk); check("valid0_lat2", 64'(valid0), 64'd0);
    @(negedge clk); check("valid0_lat3", 64'(valid0), 64'd1);
    check("distance0_19", 64'(distance0), 64'd19);
    check("timeout0_good", 64'(timeout0), 64'd0);
    @(negedge clk);
    check("valid0_one_cycle", 64'(valid0), 64'd0);
    check("near0_far", 64'(near0), 64'd0);

    // Slot 1: sensor 1, echo of 588 us with noise on echo0
    n = 0;
    while (trig1 !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("trig1_rise", 64'(trig1), 64'd1);
    check("slot_period", 64'(cyc - t0), 64'(SLOT_CYC));
    check("active_slot1", 64'(active), 64'd1);
    n = 0;
    while (trig1 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("trig1_width", 64'(n), 64'(TRIG_CYC));
    echo1 = 1'b1;
    echo0 = 1'b1;
    repeat (500) @(negedge clk);
    echo0 = 1'b0;
    repeat (W1176 / 2 - 500) @(negedge clk);
    echo1 = 1'b0;
    repeat (2) @(negedge clk);
    check("valid1_lat2", 64'(valid1), 64'd0);
    @(negedge clk);
    check("valid1_lat3", 64'(valid1), 64'd1);
    check("distance1_9", 64'(distance1), 64'd9);
    check("near1_not_yet", 64'(near1), 64'd0);
    @(negedge clk);
    check("near1_set", 64'(near1), 64'd1);
    check("noise_ignored", 64'(v0_cnt), 64'd1);

    // Slot 2: sensor 0, no echo -> timeout
    n = 0;
    while (trig0 !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    n = 0;
    while (trig0 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    fall_cyc = cyc;
    n = 0;
    while (valid0 !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    check("timeout0_latency", 64'(cyc - fall_cyc), 64'(TO_CYC));
    check("distance0_999", 64'(distance0), 64'd999);
    check("timeout0_set", 64'(timeout0), 64'd1);

    // Slot 3: sensor 1 also times out, clearing near1
    n = 0;
    while (valid1 !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
    check("distance1_999", 64'(distance1), 64'd999);
    check("timeout1_set", 64'(timeout1), 64'd1);
    @(negedge clk);
    check("near1_cleared", 64'(near1), 64'd0);

    // Slot 4: sensor 0 good echo, enable dropped 100 us into the slot
    n = 0;
    while (trig0 !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    t4 = cyc;
    repeat (200) @(negedge clk);
    enable = 1'b0;
    echo0 = 1'b1;
    repeat (W1176) @(negedge clk);
    echo0 = 1'b0;
    repeat (3) @(negedge clk);
    check("valid0_recover", 64'(valid0), 64'd1);
    check("distance0_recover", 64'(distance0), 64'd19);
    check("timeout0_cleared", 64'(timeout0), 64'd0);
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    check("slot4_completes", 64'(cyc - t4), 64'(SLOT_CYC));
    check("active_after_drop", 64'(active), 64'd1);
    tr1_snap = tr1_cnt;
    repeat (1000) @(negedge clk);
    check("idle_no_trig1", 64'(tr1_cnt - tr1_snap), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Re-enable starts with sensor 1
    enable = 1'b1;
    @(negedge clk);
    check("reenable_trig1", 64'({trig1, trig0}), 64'b10);

    // Reset asserted during MEASURE
    n = 0;
    while (trig1 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    echo1 = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", outs(), 64'd0);
    echo1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (trig0 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("restart_trig", 64'({trig1, trig0, active}), 64'b010);

    check("valid_exclusive", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
